// File: rtl/pit_multi.sv
// pit_multi: NUM_CHANNELS down-counter interval timers behind an AXI4-Lite slave, masked pending flags ORed onto irq
// Ports: s_axi_aclk / s_axi_aresetn (async, active-low); s_axi_aw*/w*/b* write channel; s_axi_ar*/r* read channel;
//        irq = OR over channels of (PENDING & CTRL.IE). Channel n occupies 0x10*n: CTRL, LOAD, COUNT, STATUS.
module pit_multi #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CHANNELS       = 4,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          irq
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int CW = COUNTER_WIDTH;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;
  w_state_t r_wstate, w_wnext;
  r_state_t r_rstate, w_rnext;
  logic [AW-3:0] r_waddr, r_raddr;
  logic [31:0] r_wdata, r_rdata, w_rsel;
  logic [3:0] r_wstrb;
  logic [1:0] r_bresp, r_rresp;
  logic [31:0] w_rword [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_irq;
  int w_wch, w_rch;
  logic w_wok, w_rok, w_wacc, w_unused;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) o[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return o;
  endfunction

  // LOAD of 0 behaves like LOAD of 1: counter parks at 0 and expires every cycle
  function automatic logic [CW-1:0] reload(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign w_wch = int'(r_waddr[AW-3:2]);
  assign w_rch = int'(r_raddr[AW-3:2]);
  assign w_wok = w_wch < NUM_CHANNELS;
  assign w_rok = w_rch < NUM_CHANNELS;
  assign w_wacc = r_wstate == W_ACCEPT;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    w_rnext = r_rstate;
    if (r_wstate == W_IDLE && s_axi_awvalid && s_axi_wvalid) w_wnext = W_ACCEPT;
    else if (r_wstate == W_ACCEPT) w_wnext = W_RESP;
    else if (r_wstate == W_RESP && s_axi_bready) w_wnext = W_IDLE;
    if (r_rstate == R_IDLE && s_axi_arvalid) w_rnext = R_ACCEPT;
    else if (r_rstate == R_ACCEPT) w_rnext = R_DATA;
    else if (r_rstate == R_DATA && s_axi_rready) w_rnext = R_IDLE;
    s_axi_awready = w_wacc;
    s_axi_wready = w_wacc;
    s_axi_bvalid = r_wstate == W_RESP;
    s_axi_arready = r_rstate == R_ACCEPT;
    s_axi_rvalid = r_rstate == R_DATA;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= '0;
      r_raddr <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
    end else begin
      if (r_wstate == W_IDLE && s_axi_awvalid && s_axi_wvalid) begin
        r_waddr <= s_axi_awaddr[AW-1:2];
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_wacc) r_bresp <= w_wok ? 2'b00 : 2'b10;
      if (r_rstate == R_IDLE && s_axi_arvalid) r_raddr <= s_axi_araddr[AW-1:2];
      if (r_rstate == R_ACCEPT) begin
        r_rdata <= w_rok ? w_rsel : '0;
        r_rresp <= w_rok ? 2'b00 : 2'b10;
      end
    end
  end

  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) w_rsel = (w_rch == i) ? w_rword[i] : w_rsel;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic r_en, r_ie, r_os, r_pend;
    logic [CW-1:0] r_load, r_cnt, w_load_new;
    logic [2:0] w_ctrl_new;
    logic w_sel, w_ctrl_we, w_load_we, w_stat_we, w_exp, w_start;
    assign w_sel = w_wacc && w_wch == c;
    assign w_ctrl_we = w_sel && r_waddr[1:0] == 2'd0;
    assign w_load_we = w_sel && r_waddr[1:0] == 2'd1;
    assign w_stat_we = w_sel && r_waddr[1:0] == 2'd3;
    assign w_ctrl_new = r_wstrb[0] ? r_wdata[2:0] : {r_os, r_ie, r_en};
    assign w_load_new = CW'(merge(32'(r_load), r_wdata, r_wstrb));
    assign w_exp = r_en && r_cnt == '0;
    assign w_start = w_ctrl_we && w_ctrl_new[0] && !r_en;
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        {r_os, r_ie, r_en} <= '0;
        r_pend <= 1'b0;
        r_load <= '0;
        r_cnt <= '0;
      end else begin
        if (w_ctrl_we) {r_os, r_ie, r_en} <= w_ctrl_new;
        else if (w_exp && r_os) r_en <= 1'b0;
        if (w_load_we) r_load <= w_load_new;
        r_cnt <= w_load_we ? reload(w_load_new) : (w_start || w_exp) ? reload(r_load) : r_en ? r_cnt - CW'(1) : r_cnt;
        // expiry outranks a simultaneous write-1-to-clear
        r_pend <= w_exp || (r_pend && !(w_stat_we && r_wstrb[0] && r_wdata[0]));
      end
    end
    assign w_irq[c] = r_pend && r_ie;
    assign w_rword[c] = (r_raddr[1:0] == 2'd0) ? {29'd0, r_os, r_ie, r_en} :
                        (r_raddr[1:0] == 2'd1) ? 32'(r_load) :
                        (r_raddr[1:0] == 2'd2) ? 32'(r_cnt) : {31'd0, r_pend};
  end

  assign irq = |w_irq;
  assign s_axi_bresp = r_bresp;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
endmodule

// File: tb/tb_pit_multi.sv
// tb_pit_multi: randomized self-checking bench for pit_multi using a time-based model of expiry and count
`timescale 1ns/1ps
module tb_pit_multi;
  localparam int AW = 7;
  localparam int NC = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  int cyc = 0, n_chk = 0, n_pass = 0;

  pit_multi #(.C_S_AXI_ADDR_WIDTH(AW), .NUM_CHANNELS(NC), .COUNTER_WIDTH(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // teff = cycle stamp right after the edge on which the register update lands
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int teff);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int k = 0; k < 10 && !awready; k++) idle(1);
    n_chk++;
    if (!awready) $display("FAIL aw_handshake awready=%b required 1", awready); else n_pass++;
    idle(1);
    awvalid = 1'b0; wvalid = 1'b0; teff = cyc; resp = bresp;
    n_chk++;
    if (bvalid !== 1'b1) $display("FAIL bvalid_latency bvalid=%b required 1", bvalid); else n_pass++;
    idle(1);
  endtask

  // tr = cycle stamp whose register state the returned data reflects
  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp, output int tr);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int k = 0; k < 10 && !arready; k++) idle(1);
    n_chk++;
    if (!arready) $display("FAIL ar_handshake arready=%b required 1", arready); else n_pass++;
    tr = cyc;
    idle(1);
    arvalid = 1'b0; d = rdata; resp = rresp;
    n_chk++;
    if (rvalid !== 1'b1) $display("FAIL rvalid_latency rvalid=%b required 1", rvalid); else n_pass++;
    idle(1);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int t;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid, irq, bresp, rresp, rdata} !== '0)
      $display("FAIL reset_outputs got %h required 0", {awready, wready, bvalid, arready, rvalid, irq, bresp, rresp, rdata});
    else n_pass++;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    for (int a = 0; a < NC * 16; a += 4) begin
      axi_read(AW'(a), d, r, t);
      n_chk++;
      if ({d, r} !== 34'd0) $display("FAIL reset_reg addr=%h data=%h resp=%b required 0/00", a, d, r); else n_pass++;
    end
    axi_read(AW'(8'h40), d, r, t);
    n_chk++;
    if (d !== 32'd0 || r !== 2'b10) $display("FAIL oob_read data=%h resp=%b required 0/10", d, r); else n_pass++;
    axi_write(AW'(8'h44), 32'h1234, 4'hf, r, t);
    n_chk++;
    if (r !== 2'b10) $display("FAIL oob_write resp=%b required 10", r); else n_pass++;
  endtask

  task automatic test_periodic();
    logic [31:0] d; logic [1:0] r; int t0, tc, tr, t, ch, L;
    for (int it = 0; it < 3; it++) begin
      ch = (it == 0) ? 0 : int'($urandom_range(0, NC - 1));
      L = (it == 0) ? 5 : int'($urandom_range(1, 9));
      axi_write(AW'(ch * 16 + 4), 32'(L), 4'hf, r, t);
      axi_write(AW'(ch * 16), 32'h3, 4'hf, r, t0);
      for (int k = 0; k < 2 * L + 2; k++) begin
        n_chk++;
        if (irq !== ((cyc - t0) >= L)) $display("FAIL periodic_irq ch=%0d L=%0d d=%0d irq=%b", ch, L, cyc - t0, irq); else n_pass++;
        idle(1);
      end
      axi_write(AW'(ch * 16 + 12), 32'h1, 4'h1, r, tc);
      for (int k = 0; k < 2 * L + 2; k++) begin
        n_chk++;
        if (irq !== (((cyc - t0) / L > (tc - t0) / L) || ((tc - t0) % L == 0)))
          $display("FAIL w1c_irq ch=%0d L=%0d d=%0d dc=%0d irq=%b", ch, L, cyc - t0, tc - t0, irq);
        else n_pass++;
        idle(1);
      end
      for (int k = 0; k < 3; k++) begin
        idle(int'($urandom_range(0, 7)));
        axi_read(AW'(ch * 16 + 8), d, r, tr);
        n_chk++;
        if (d !== 32'((L - 1) - ((tr - t0) % L)) || r !== 2'b00)
          $display("FAIL periodic_count ch=%0d L=%0d d=%0d got %0d required %0d", ch, L, tr - t0, d, (L - 1) - ((tr - t0) % L));
        else n_pass++;
      end
      axi_write(AW'(ch * 16), 32'h0, 4'hf, r, t);
      axi_write(AW'(ch * 16 + 12), 32'h1, 4'hf, r, t);
      axi_read(AW'(ch * 16 + 12), d, r, t);
      n_chk++;
      if (d !== 32'd0) $display("FAIL periodic_cleanup ch=%0d status=%h required 0", ch, d); else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic [1:0] r; int t0, tr, t, L;
    for (int it = 0; it < 2; it++) begin
      L = (it == 0) ? 3 : int'($urandom_range(2, 10));
      axi_write(AW'(8'h24), 32'(L), 4'hf, r, t);
      axi_write(AW'(8'h20), 32'h7, 4'hf, r, t0);
      axi_read(AW'(8'h28), d, r, tr);
      n_chk++;
      if (d !== 32'(((tr - t0) < L) ? (L - 1) - (tr - t0) : L - 1))
        $display("FAIL oneshot_early_count L=%0d d=%0d got %0d", L, tr - t0, d);
      else n_pass++;
      idle(L + 2);
      axi_read(AW'(8'h20), d, r, tr);
      n_chk++;
      if (d !== 32'h6) $display("FAIL oneshot_ctrl got %h required 6", d); else n_pass++;
      axi_read(AW'(8'h28), d, r, tr);
      n_chk++;
      if (d !== 32'(L - 1)) $display("FAIL oneshot_hold got %0d required %0d", d, L - 1); else n_pass++;
      axi_read(AW'(8'h2C), d, r, tr);
      n_chk++;
      if (d !== 32'h1 || irq !== 1'b1) $display("FAIL oneshot_pending status=%h irq=%b required 1/1", d, irq); else n_pass++;
      axi_write(AW'(8'h2C), 32'h1, 4'hf, r, t);
      idle(2 * L + 2);
      axi_read(AW'(8'h2C), d, r, tr);
      n_chk++;
      if (d !== 32'h0 || irq !== 1'b0) $display("FAIL oneshot_no_rearm status=%h irq=%b required 0/0", d, irq); else n_pass++;
      axi_write(AW'(8'h20), 32'h0, 4'hf, r, t);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d; logic [1:0] r; int t0, tr, t;
    axi_write(AW'(8'h14), 32'd4, 4'hf, r, t);
    axi_write(AW'(8'h10), 32'h1, 4'hf, r, t0);
    axi_read(AW'(8'h1C), d, r, tr);
    n_chk++;
    if (d !== 32'((tr - t0) >= 4)) $display("FAIL mask_early_status d=%0d got %h", tr - t0, d); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (irq !== 1'b0) $display("FAIL mask_irq_low irq=%b required 0", irq); else n_pass++;
      idle(1);
    end
    axi_read(AW'(8'h1C), d, r, tr);
    n_chk++;
    if (d !== 32'h1) $display("FAIL mask_status got %h required 1", d); else n_pass++;
    axi_write(AW'(8'h10), 32'h3, 4'hf, r, t);
    n_chk++;
    if (irq !== 1'b1) $display("FAIL mask_ie_set irq=%b required 1", irq); else n_pass++;
    axi_write(AW'(8'h10), 32'h1, 4'hf, r, t);
    n_chk++;
    if (irq !== 1'b0) $display("FAIL mask_ie_clear irq=%b required 0", irq); else n_pass++;
    axi_write(AW'(8'h10), 32'h0, 4'hf, r, t);
    axi_write(AW'(8'h1C), 32'h1, 4'hf, r, t);
  endtask

  task automatic test_w1c_race_and_strobes();
    logic [31:0] d, o, n, e; logic [1:0] r; logic [3:0] s; int t;
    axi_write(AW'(8'h04), 32'd1, 4'hf, r, t);
    axi_write(AW'(8'h00), 32'h1, 4'hf, r, t);
    idle(2);
    axi_write(AW'(8'h0C), 32'h1, 4'hf, r, t);
    axi_read(AW'(8'h0C), d, r, t);
    n_chk++;
    if (d !== 32'h1) $display("FAIL w1c_race status=%h required 1", d); else n_pass++;
    axi_write(AW'(8'h00), 32'h0, 4'hf, r, t);
    axi_write(AW'(8'h0C), 32'h1, 4'hf, r, t);
    axi_read(AW'(8'h0C), d, r, t);
    n_chk++;
    if (d !== 32'h0) $display("FAIL w1c_clear status=%h required 0", d); else n_pass++;
    axi_write(AW'(8'h04), 32'h0, 4'hf, r, t);
    axi_write(AW'(8'h04), 32'hAABBCC10, 4'b0001, r, t);
    axi_read(AW'(8'h04), d, r, t);
    n_chk++;
    if (d !== 32'h10) $display("FAIL strobe_load got %h required 10", d); else n_pass++;
    for (int it = 0; it < 4; it++) begin
      o = $urandom; n = $urandom; s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) e[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
      axi_write(AW'(8'h34), o, 4'hf, r, t);
      axi_write(AW'(8'h34), n, s, r, t);
      axi_read(AW'(8'h34), d, r, t);
      n_chk++;
      if (d !== e) $display("FAIL strobe_rand strb=%b got %h required %h", s, d, e); else n_pass++;
      axi_write(AW'(8'h38), 32'h1234, 4'hf, r, t);
      n_chk++;
      if (r !== 2'b00) $display("FAIL count_write_resp got %b required 00", r); else n_pass++;
      axi_read(AW'(8'h38), d, r, t);
      n_chk++;
      if (d !== ((e == 0) ? 32'd0 : e - 1)) $display("FAIL count_ro got %h required %h", d, (e == 0) ? 32'd0 : e - 1); else n_pass++;
    end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] d; logic [1:0] r; int t;
    axi_write(AW'(8'h04), 32'd7, 4'hf, r, t);
    axi_write(AW'(8'h00), 32'h3, 4'hf, r, t);
    awaddr = AW'(8'h04); wdata = 32'd9; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int k = 0; k < 10 && !awready; k++) idle(1);
    idle(1);
    awvalid = 1'b0; wvalid = 1'b0;
    idle(2);
    n_chk++;
    if (bvalid !== 1'b1) $display("FAIL bvalid_hold bvalid=%b required 1", bvalid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bvalid, irq, bresp} !== 4'd0) $display("FAIL async_reset bvalid=%b irq=%b bresp=%b required 0", bvalid, irq, bresp); else n_pass++;
    idle(2);
    rst_n = 1'b1;
    bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      n_chk++;
      if (bvalid !== 1'b0) $display("FAIL stale_bresp bvalid=%b required 0", bvalid); else n_pass++;
    end
    for (int a = 0; a < 16; a += 4) begin
      axi_read(AW'(a), d, r, t);
      n_chk++;
      if (d !== 32'd0) $display("FAIL reset_clears addr=%h got %h required 0", a, d); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_mask();
    test_w1c_race_and_strobes();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
